// File: rtl/regfile_wr_arbiter_if.sv
// Write-back bus of the register-file write arbiter: two write-back
// requesters, the register-file write port, destination reservations,
// hazard queries and status.
interface regfile_wr_arbiter_if;
  logic        hold;
  logic        alu_wr_valid;
  logic        alu_wr_ready;
  logic [3:0]  alu_wr_addr;
  logic [3:0]  alu_wr_data;
  logic        mem_wr_valid;
  logic        mem_wr_ready;
  logic [3:0]  mem_wr_addr;
  logic [3:0]  mem_wr_data;
  logic        rf_write_enable;
  logic [3:0]  rf_write_addr;
  logic [3:0]  rf_write_data;
  logic        rsv_valid;
  logic        rsv_ready;
  logic [3:0]  rsv_addr;
  logic [3:0]  chk_addr_a;
  logic [3:0]  chk_addr_b;
  logic        chk_hazard_a;
  logic        chk_hazard_b;
  logic [15:0] busy;
  logic        err_unreserved;

  // Pipeline side: execute/memory/decode stages driving the arbiter.
  modport master (
    output hold, alu_wr_valid, alu_wr_addr, alu_wr_data,
           mem_wr_valid, mem_wr_addr, mem_wr_data,
           rsv_valid, rsv_addr, chk_addr_a, chk_addr_b,
    input  alu_wr_ready, mem_wr_ready, rf_write_enable, rf_write_addr,
           rf_write_data, rsv_ready, chk_hazard_a, chk_hazard_b,
           busy, err_unreserved
  );

  // Arbiter side.
  modport slave (
    input  hold, alu_wr_valid, alu_wr_addr, alu_wr_data,
           mem_wr_valid, mem_wr_addr, mem_wr_data,
           rsv_valid, rsv_addr, chk_addr_a, chk_addr_b,
    output alu_wr_ready, mem_wr_ready, rf_write_enable, rf_write_addr,
           rf_write_data, rsv_ready, chk_hazard_a, chk_hazard_b,
           busy, err_unreserved
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Shares the single register-file write port between the ALU (requester 0)
// and the load unit (requester 1), and keeps a per-register count of
// outstanding writes so decode can detect read-after-write hazards.
module regfile_wr_arbiter #(
  parameter bit FAIR  = 1'b1,
  parameter int CNT_W = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  regfile_wr_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {PTR_ALU = 1'b0, PTR_MEM = 1'b1} ptr_e;

  ptr_e             rr_ptr;
  logic [CNT_W-1:0] cnt [16];
  logic             open;
  logic             grant_alu;
  logic             grant_mem;
  logic             accept;
  logic [3:0]       acc_addr;
  logic [3:0]       acc_data;
  logic             rsv_fire;
  logic [15:0]      inc_vec;
  logic [15:0]      dec_vec;
  logic [15:0]      busy_w;
  logic             we_q;
  logic [3:0]       addr_q;
  logic [3:0]       data_q;
  logic             err_q;

  // Nothing is granted while held or in reset.
  assign open = rst_n & ~bus.hold;

  // Grant selection: lone requester wins; on contention the pointer owner
  // (round-robin) or the ALU (fixed priority) wins.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path infers a latch.
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (open) begin
      if (bus.alu_wr_valid && bus.mem_wr_valid) begin
        if (!FAIR || rr_ptr == PTR_ALU) grant_alu = 1'b1;
        else                            grant_mem = 1'b1;
      end else begin
        grant_alu = bus.alu_wr_valid;
        grant_mem = bus.mem_wr_valid;
      end
    end
  end

  assign accept   = grant_alu | grant_mem;
  assign acc_addr = grant_alu ? bus.alu_wr_addr : bus.mem_wr_addr;
  assign acc_data = grant_alu ? bus.alu_wr_data : bus.mem_wr_data;

  assign bus.alu_wr_ready = grant_alu;
  assign bus.mem_wr_ready = grant_mem;

  // A saturated counter refuses a reservation unless a write to the same
  // register retires in this cycle, which leaves the count unchanged.
  assign bus.rsv_ready = open &&
                         (cnt[bus.rsv_addr] != CNT_MAX ||
                          (accept && acc_addr == bus.rsv_addr));
  assign rsv_fire = bus.rsv_valid & bus.rsv_ready;

  // Per-register increment/decrement requests and busy flags; r0 never counts.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    busy_w  = '0;
    for (int i = 1; i < 16; i++) begin
      inc_vec[i] = rsv_fire && bus.rsv_addr == 4'(i);
      dec_vec[i] = accept && acc_addr == 4'(i);
      busy_w[i]  = cnt[i] != '0;
    end
  end

  assign bus.busy         = busy_w;
  assign bus.chk_hazard_a = busy_w[bus.chk_addr_a];
  assign bus.chk_hazard_b = busy_w[bus.chk_addr_b];

  // Round-robin pointer: passes to the other requester after each grant.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n)         rr_ptr <= PTR_ALU;
    else if (grant_alu) rr_ptr <= PTR_MEM;
    else if (grant_mem) rr_ptr <= PTR_ALU;
  end

  // Outstanding-write counters and the sticky unreserved-write error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the counter array is plain flops that must start empty, so it is reset like any register.
      for (int i = 0; i < 16; i++) cnt[i] <= '0;
      err_q <= 1'b0;
    end else begin
      for (int i = 1; i < 16; i++) begin
        if (inc_vec[i] && !dec_vec[i]) begin
          cnt[i] <= cnt[i] + 1'b1;
        end else if (dec_vec[i] && !inc_vec[i]) begin
          if (cnt[i] != '0) cnt[i] <= cnt[i] - 1'b1;
          else              err_q  <= 1'b1;
        end
      end
    end
  end

  // Registered write port: one cycle after an accept; r0 writes are dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      we_q <= accept && acc_addr != 4'd0;
      if (accept && acc_addr != 4'd0) begin
        addr_q <= acc_addr;
        data_q <= acc_data;
      end
    end
  end

  assign bus.rf_write_enable = we_q;
  assign bus.rf_write_addr   = addr_q;
  assign bus.rf_write_data   = data_q;
  assign bus.err_unreserved  = err_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: a behavioural model predicts
// grants, counters and errors; expected register-file writes are queued when
// stimulus is applied and compared one cycle later.
module tb_regfile_wr_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_wr_arbiter_if m ();
  regfile_wr_arbiter_if f ();

  regfile_wr_arbiter #(.FAIR(1'b1), .CNT_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (m.slave)
  );

  regfile_wr_arbiter #(.FAIR(1'b0), .CNT_W(2)) dut_fp (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (f.slave)
  );

  typedef struct {
    logic [3:0] addr;
    logic [3:0] data;
  } wr_t;

  wr_t        exp_q[$];
  int         cnt_m[16];
  bit         ptr_m;     // 0 = ALU owns the pointer
  bit         err_m;
  logic [3:0] addr_m;
  logic [3:0] data_m;
  int         errors = 0;
  int         checks = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) cnt_m[i] = 0;
    ptr_m  = 1'b0;
    err_m  = 1'b0;
    addr_m = '0;
    data_m = '0;
    exp_q.delete();
  endtask

  task automatic idle();
    m.hold = 0; m.alu_wr_valid = 0; m.mem_wr_valid = 0; m.rsv_valid = 0;
  endtask

  // One clock of the main DUT: check combinational outputs against the model,
  // advance the model, then check registered outputs after the edge.
  task automatic cycle();
    logic        ea, em, acc, er, inc;
    logic [3:0]  aa, ad;
    logic [15:0] bz;
    wr_t         w;
    #1;
    ea = 0; em = 0;
    if (rst_n && !m.hold) begin
      if (m.alu_wr_valid && m.mem_wr_valid) begin
        ea = (ptr_m == 1'b0);
        em = !ea;
      end else begin
        ea = m.alu_wr_valid;
        em = m.mem_wr_valid;
      end
    end
    acc = ea | em;
    aa  = ea ? m.alu_wr_addr : m.mem_wr_addr;
    ad  = ea ? m.alu_wr_data : m.mem_wr_data;
    er  = rst_n && !m.hold && (cnt_m[m.rsv_addr] != 3 || (acc && aa == m.rsv_addr));
    bz  = '0;
    for (int i = 1; i < 16; i++) bz[i] = cnt_m[i] != 0;
    check("alu_wr_ready", m.alu_wr_ready, ea);
    check("mem_wr_ready", m.mem_wr_ready, em);
    check("rsv_ready", m.rsv_ready, er);
    check("busy", m.busy, bz);
    check("chk_hazard_a", m.chk_hazard_a, bz[m.chk_addr_a]);
    check("chk_hazard_b", m.chk_hazard_b, bz[m.chk_addr_b]);

    if (!rst_n) begin
      model_reset();
    end else begin
      inc = m.rsv_valid && er && m.rsv_addr != 0;
      if (!(inc && acc && aa == m.rsv_addr)) begin
        if (inc) cnt_m[m.rsv_addr]++;
        if (acc && aa != 0) begin
          if (cnt_m[aa] == 0) err_m = 1'b1;
          else                cnt_m[aa]--;
        end
      end
      if (acc && aa != 0) begin
        w.addr = aa;
        w.data = ad;
        exp_q.push_back(w);
      end
      if (ea) ptr_m = 1'b1;
      if (em) ptr_m = 1'b0;
    end

    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      w = exp_q.pop_front();
      addr_m = w.addr;
      data_m = w.data;
      check("rf_write_enable", m.rf_write_enable, 1'b1);
    end else begin
      check("rf_write_enable", m.rf_write_enable, 1'b0);
    end
    check("rf_write_addr", m.rf_write_addr, addr_m);
    check("rf_write_data", m.rf_write_data, data_m);
    check("err_unreserved", m.err_unreserved, err_m);
    @(negedge clk);
  endtask

  task automatic reserve(input logic [3:0] a);
    idle();
    m.rsv_valid = 1; m.rsv_addr = a;
    cycle();
    idle();
  endtask

  task automatic alu_write(input logic [3:0] a, input logic [3:0] d);
    idle();
    m.alu_wr_valid = 1; m.alu_wr_addr = a; m.alu_wr_data = d;
    cycle();
    idle();
  endtask

  initial begin
    f.hold = 0; f.alu_wr_valid = 0; f.mem_wr_valid = 0; f.rsv_valid = 0;
    f.alu_wr_addr = 0; f.alu_wr_data = 0; f.mem_wr_addr = 0; f.mem_wr_data = 0;
    f.rsv_addr = 0; f.chk_addr_a = 0; f.chk_addr_b = 0;
    idle();
    m.alu_wr_addr = 0; m.alu_wr_data = 0; m.mem_wr_addr = 0; m.mem_wr_data = 0;
    m.rsv_addr = 0; m.chk_addr_a = 5; m.chk_addr_b = 0;
    model_reset();

    // Reset state.
    @(negedge clk);
    rst_n = 0;
    cycle();
    cycle();
    check("reset busy", m.busy, 16'h0000);
    check("reset rf_write_enable", m.rf_write_enable, 1'b0);
    rst_n = 1;
    cycle();

    // Reserve r5, then a single ALU write to r5.
    reserve(4'd5);
    check("r5 busy after reserve", m.busy[5], 1'b1);
    alu_write(4'd5, 4'hA);
    check("r5 busy after write", m.busy[5], 1'b0);

    // r0: handshake completes, no write, no error, reservation ignored.
    m.alu_wr_valid = 1; m.alu_wr_addr = 0; m.alu_wr_data = 4'hF;
    m.rsv_valid = 1; m.rsv_addr = 0;
    cycle();
    idle();
    check("r0 no write", m.rf_write_enable, 1'b0);
    check("r0 no error", m.err_unreserved, 1'b0);

    // Reserve r3 and r4 twice each, then contend; fixed-priority twin in parallel.
    reserve(4'd3); reserve(4'd4); reserve(4'd3); reserve(4'd4);
    for (int k = 0; k < 4; k++) begin
      m.alu_wr_valid = 1; m.alu_wr_addr = 3; m.alu_wr_data = 4'(k);
      m.mem_wr_valid = 1; m.mem_wr_addr = 4; m.mem_wr_data = 4'(k + 8);
      f.alu_wr_valid = 1; f.alu_wr_addr = 3; f.alu_wr_data = 4'(k);
      f.mem_wr_valid = 1; f.mem_wr_addr = 4; f.mem_wr_data = 4'(k + 8);
      #1;
      check("fp alu_wr_ready", f.alu_wr_ready, 1'b1);
      check("fp mem_wr_ready", f.mem_wr_ready, 1'b0);
      cycle();
      check("fp rf_write_addr", f.rf_write_addr, 4'd3);
    end
    f.alu_wr_valid = 0; f.mem_wr_valid = 0;
    idle();
    check("fair no error", m.err_unreserved, 1'b0);

    // Hold freezes grants.
    m.hold = 1; m.alu_wr_valid = 1; m.mem_wr_valid = 1;
    cycle();
    idle();

    // Saturate r7, then reserve + write in the same cycle.
    m.chk_addr_a = 7;
    reserve(4'd7); reserve(4'd7); reserve(4'd7);
    m.rsv_valid = 1; m.rsv_addr = 7;
    #1;
    check("r7 saturated rsv_ready", m.rsv_ready, 1'b0);
    cycle();
    m.alu_wr_valid = 1; m.alu_wr_addr = 7; m.alu_wr_data = 4'h6;
    cycle();
    idle();
    check("r7 count held busy", m.busy[7], 1'b1);
    alu_write(4'd7, 4'h1);
    alu_write(4'd7, 4'h2);

    // Hazard on r7 (count 1) clears the cycle after the retiring write.
    m.alu_wr_valid = 1; m.alu_wr_addr = 7; m.alu_wr_data = 4'h3;
    #1;
    check("hazard_a during write", m.chk_hazard_a, 1'b1);
    cycle();
    idle();
    check("hazard_a after write", m.chk_hazard_a, 1'b0);

    // Unreserved load write to r9 sets a sticky error.
    m.mem_wr_valid = 1; m.mem_wr_addr = 9; m.mem_wr_data = 4'h4;
    cycle();
    idle();
    check("err set", m.err_unreserved, 1'b1);
    cycle();
    check("err sticky", m.err_unreserved, 1'b1);

    // Reset with hold and both requesters valid clears everything.
    rst_n = 0; m.hold = 1; m.alu_wr_valid = 1; m.mem_wr_valid = 1;
    cycle();
    check("reset err cleared", m.err_unreserved, 1'b0);
    check("reset write addr", m.rf_write_addr, 4'd0);
    rst_n = 1;
    idle();
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Shares the single write port of the 16 x 4-bit register file between two write-back requesters: ALU (requester 0) and memory-load (requester 1).
- Tracks in-flight producers per register in a scoreboard so the decode stage can detect read-after-write hazards.
- Sits between execute/memory stages and the register file write port; drives write_enable/write_addr/write_data from a registered output stage.

Parameters:
- FAIR, 1, 1 = round-robin between requesters; 0 = fixed priority, ALU always wins
- CNT_W, 2, width of per-register outstanding-write counter; saturates at 2^CNT_W-1

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- hold  input  1  freeze grants (debug/stall); no handshake completes while high
- alu_wr_valid  input  1  ALU write-back request
- alu_wr_ready  output  1  ALU request accepted this cycle
- alu_wr_addr  input  4  ALU destination register
- alu_wr_data  input  4  ALU result
- mem_wr_valid  input  1  load write-back request
- mem_wr_ready  output  1  load request accepted this cycle
- mem_wr_addr  input  4  load destination register
- mem_wr_data  input  4  load data
- rf_write_enable  output  1  to register file write_enable
- rf_write_addr  output  4  to register file write_addr
- rf_write_data  output  4  to register file write_data
- rsv_valid  input  1  decode reserves a destination for an issued instruction
- rsv_ready  output  1  reservation can be accepted
- rsv_addr  input  4  register being reserved
- chk_addr_a  input  4  source A to hazard-check
- chk_addr_b  input  4  source B to hazard-check
- chk_hazard_a  output  1  source A has an outstanding write
- chk_hazard_b  output  1  source B has an outstanding write
- busy  output  16  per-register outstanding flag (bit i = count[i] != 0)
- err_unreserved  output  1  sticky: write accepted to a register with zero outstanding count

Behaviour:
- One clock; reset is synchronous, active-low: on clk edge with rst_n=0, all counters, RR pointer (points to ALU), rf_write_enable, rf_write_addr, rf_write_data, and err_unreserved are cleared to 0. Reset mid-operation discards any pending grant; no write is issued the cycle after.
- Readies are combinational from valids, hold and the RR pointer. At most one of alu_wr_ready/mem_wr_ready is high per cycle; both are 0 while hold=1 or rst_n=0.
- Only one valid: that requester is granted. Both valid, FAIR=1: pointer owner is granted, and the pointer moves to the other requester after each grant. Both valid, FAIR=0: ALU is granted. The pointer is unchanged when no grant occurs.
- Requesters hold addr/data stable while valid and not ready.
- Output stage, latency 1: on the edge after an accept with addr!=0, rf_write_enable=1 with the granted addr/data. Otherwise rf_write_enable=0 and addr/data hold their last values.
- r0: an accepted write to r0 completes the handshake but produces rf_write_enable=0. Reservations of r0 are accepted and ignored. chk_hazard_* is always 0 for address 0. busy[0]=0.
- Scoreboard, per register i != 0:
  - Reserve (rsv_valid & rsv_ready & rsv_addr=i) increments count[i].
  - Accepted write to i decrements count[i].
  - Both in the same cycle: count unchanged.
- rsv_ready = 0 when count[rsv_addr] is saturated (3 at default), unless a write to rsv_addr is accepted in the same cycle.
- Accepted write to i with count[i]=0: count stays 0, err_unreserved set; it is cleared only by reset.
- chk_hazard_x = busy[chk_addr_x] (combinational, reflects registered counts). A write accepted this cycle clears hazard from the next cycle, matching the register file update.

Test Plan:
- Reset, then alu_wr_valid=1, addr=5, data=A after rsv 5 -> alu_wr_ready=1 same cycle; next cycle rf_write_enable=1, addr=5, data=A; busy[5] goes 1 -> 0.
- Both valid every cycle (ALU addr 3, mem addr 4), FAIR=1 -> grants alternate ALU, mem, ALU, mem; with FAIR=0 -> ALU granted every cycle, mem_wr_ready stays 0.
- ALU write to r0 data F -> handshake completes, rf_write_enable stays 0, err_unreserved stays 0.
- Reserve r7 three times -> busy[7]=1, rsv_ready=0 for addr 7; a write to 7 with a simultaneous reserve of 7 is accepted and count stays 3.
- chk_addr_a=7 while count[7]=1, write to 7 accepted at cycle N -> chk_hazard_a=1 through cycle N, 0 at N+1.
- Write to unreserved r9 -> err_unreserved=1 and stays 1. Assert rst_n=0 with hold=1 and both valid -> all outputs 0, readies 0, err cleared.
